// File: rtl/t_flip_flop_pkg.sv
// Shared definitions for the toggle flip-flop bank: width limit and next-state rule.
// Latency: n/a (package only).
// Backpressure: none.
package t_flip_flop_pkg;

    localparam int MAX_WIDTH = 64;

    // Next value of one flip-flop; priority is reset, then load, then enabled toggle, else hold.
    function automatic logic toggle_next(
        input logic q,
        input logic t,
        input logic en,
        input logic load,
        input logic d,
        input logic rst,
        input logic rst_val
    );
        if (rst)
            return rst_val;
        else if (load)
            return d;
        else if (en)
            return q ^ t;
        else
            return q;
    endfunction

endpackage

// File: rtl/t_flip_flop_cell.sv
// Single T flip-flop with clock enable, parallel load and synchronous reset.
// Latency: q and toggled update one cycle after the sampling edge.
// Backpressure: none; every edge is consumed.
module t_flip_flop_cell
    import t_flip_flop_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic t,
    input  logic en,
    input  logic load,
    input  logic d,
    output logic q,
    output logic toggled
);

    logic nxt;

    assign nxt = toggle_next(q, t, en, load, d, rst, RESET_VAL);

    // toggled is simply "did q change", except that a reset edge always reports no change.
    always_ff @(posedge clk) begin
        q       <= nxt;
        toggled <= rst ? 1'b0 : (q ^ nxt);
    end

endmodule

// File: rtl/t_flip_flop.sv
// Bank of WIDTH independent T flip-flops with enable, load, inverse and change flags.
// Latency: Q/toggled one cycle after the sampling edge; Q_n combinational from Q.
// Backpressure: none; every edge is consumed.
module t_flip_flop
    import t_flip_flop_pkg::*;
#(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] T,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic [WIDTH-1:0] toggled
);

    generate
        if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("t_flip_flop: WIDTH out of range 1..64");
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_flip_flop_cell #(
            .RESET_VAL (RESET_VAL[i])
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .t       (T[i]),
            .en      (en),
            .load    (load),
            .d       (d[i]),
            .q       (Q[i]),
            .toggled (toggled[i])
        );
    end

    assign Q_n = ~Q;

endmodule

// File: tb/tb_t_flip_flop.sv
// Directed and randomized checks of the T flip-flop bank in three configurations.
module tb_t_flip_flop;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=1, RESET_VAL=0
    logic rst1, t1, en1, load1, d1, q1, qn1, tg1;
    // WIDTH=4, RESET_VAL=0
    logic rst4, en4, load4;
    logic [3:0] t4, d4, q4, qn4, tg4;
    // WIDTH=4, RESET_VAL=1100
    logic rstr, enr, loadr;
    logic [3:0] tr, dr, qr, qnr, tgr;

    int vectors = 0;
    int miscompares = 0;

    t_flip_flop #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .rst(rst1), .T(t1), .en(en1), .load(load1), .d(d1),
        .Q(q1), .Q_n(qn1), .toggled(tg1)
    );

    t_flip_flop #(.WIDTH(4), .RESET_VAL(4'b0000)) dut4 (
        .clk(clk), .rst(rst4), .T(t4), .en(en4), .load(load4), .d(d4),
        .Q(q4), .Q_n(qn4), .toggled(tg4)
    );

    t_flip_flop #(.WIDTH(4), .RESET_VAL(4'b1100)) dutr (
        .clk(clk), .rst(rstr), .T(tr), .en(enr), .load(loadr), .d(dr),
        .Q(qr), .Q_n(qnr), .toggled(tgr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst1 = 1; t1 = 1; en1 = 1; load1 = 0; d1 = 0;
        rst4 = 1; t4 = 4'b1111; en4 = 1; load4 = 0; d4 = 0;
        rstr = 1; tr = 4'b1111; enr = 1; loadr = 0; dr = 0;
        tick();
        vectors++; if (q1 !== 1'b0) begin miscompares++; $display("FAIL reset_q1 got=%b exp=0", q1); end
        vectors++; if (qn1 !== 1'b1) begin miscompares++; $display("FAIL reset_qn1 got=%b exp=1", qn1); end
        vectors++; if (tg1 !== 1'b0) begin miscompares++; $display("FAIL reset_tg1 got=%b exp=0", tg1); end
        vectors++; if (q4 !== 4'b0000) begin miscompares++; $display("FAIL reset_q4 got=%b exp=0000", q4); end
        vectors++; if (tg4 !== 4'b0000) begin miscompares++; $display("FAIL reset_tg4 got=%b exp=0000", tg4); end
        vectors++; if (qr !== 4'b1100) begin miscompares++; $display("FAIL reset_qr got=%b exp=1100", qr); end
        vectors++; if (qnr !== 4'b0011) begin miscompares++; $display("FAIL reset_qnr got=%b exp=0011", qnr); end
        vectors++; if (tgr !== 4'b0000) begin miscompares++; $display("FAIL reset_tgr got=%b exp=0000", tgr); end
    endtask

    task automatic test_single_bit();
        rst1 = 0; t1 = 0; en1 = 1;
        tick();
        vectors++; if (q1 !== 1'b0) begin miscompares++; $display("FAIL bit_hold_q got=%b exp=0", q1); end
        vectors++; if (qn1 !== 1'b1) begin miscompares++; $display("FAIL bit_hold_qn got=%b exp=1", qn1); end
        t1 = 1;
        tick();
        vectors++; if (q1 !== 1'b1) begin miscompares++; $display("FAIL bit_tog1_q got=%b exp=1", q1); end
        vectors++; if (tg1 !== 1'b1) begin miscompares++; $display("FAIL bit_tog1_tg got=%b exp=1", tg1); end
        tick();
        vectors++; if (q1 !== 1'b0) begin miscompares++; $display("FAIL bit_tog2_q got=%b exp=0", q1); end
        t1 = 0;
        tick();
        vectors++; if (q1 !== 1'b0) begin miscompares++; $display("FAIL bit_t0_q got=%b exp=0", q1); end
        vectors++; if (tg1 !== 1'b0) begin miscompares++; $display("FAIL bit_t0_tg got=%b exp=0", tg1); end
    endtask

    task automatic test_toggle_pattern();
        logic [3:0] exp_q [3];
        exp_q[0] = 4'b1010; exp_q[1] = 4'b0000; exp_q[2] = 4'b1010;
        rst4 = 0; en4 = 1; load4 = 0; t4 = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (q4 !== exp_q[i]) begin miscompares++; $display("FAIL pattern_q[%0d] got=%b exp=%b", i, q4, exp_q[i]); end
            vectors++; if (tg4 !== 4'b1010) begin miscompares++; $display("FAIL pattern_tg[%0d] got=%b exp=1010", i, tg4); end
            vectors++; if (qn4 !== ~exp_q[i]) begin miscompares++; $display("FAIL pattern_qn[%0d] got=%b exp=%b", i, qn4, ~exp_q[i]); end
        end
    endtask

    task automatic test_enable_hold();
        // Q is 1010 here; load 0101 first
        load4 = 1; d4 = 4'b0101; en4 = 0; t4 = 4'b0000;
        tick();
        vectors++; if (q4 !== 4'b0101) begin miscompares++; $display("FAIL hold_load_q got=%b exp=0101", q4); end
        vectors++; if (tg4 !== 4'b1111) begin miscompares++; $display("FAIL hold_load_tg got=%b exp=1111", tg4); end
        load4 = 0; en4 = 0; t4 = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++; if (q4 !== 4'b0101) begin miscompares++; $display("FAIL hold_q[%0d] got=%b exp=0101", i, q4); end
            vectors++; if (tg4 !== 4'b0000) begin miscompares++; $display("FAIL hold_tg[%0d] got=%b exp=0000", i, tg4); end
        end
    endtask

    task automatic test_load_priority();
        load4 = 1; d4 = 4'b0011; en4 = 1; t4 = 4'b0000;
        tick();
        vectors++; if (q4 !== 4'b0011) begin miscompares++; $display("FAIL load_pre_q got=%b exp=0011", q4); end
        vectors++; if (tg4 !== 4'b0110) begin miscompares++; $display("FAIL load_pre_tg got=%b exp=0110", tg4); end
        d4 = 4'b0110; t4 = 4'b1111;
        tick();
        vectors++; if (q4 !== 4'b0110) begin miscompares++; $display("FAIL load_win_q got=%b exp=0110", q4); end
        vectors++; if (tg4 !== 4'b0101) begin miscompares++; $display("FAIL load_win_tg got=%b exp=0101", tg4); end
        load4 = 0;
        tick();
        vectors++; if (q4 !== 4'b1001) begin miscompares++; $display("FAIL load_after_q got=%b exp=1001", q4); end
        vectors++; if (tg4 !== 4'b1111) begin miscompares++; $display("FAIL load_after_tg got=%b exp=1111", tg4); end
    endtask

    task automatic test_reset_priority();
        rstr = 0; enr = 1; loadr = 0; tr = 4'b0011;
        tick();
        vectors++; if (qr !== 4'b1111) begin miscompares++; $display("FAIL rstpri_pre_q got=%b exp=1111", qr); end
        rstr = 1; loadr = 1; dr = 4'b0011; tr = 4'b1111;
        tick();
        vectors++; if (qr !== 4'b1100) begin miscompares++; $display("FAIL rstpri_q got=%b exp=1100", qr); end
        vectors++; if (tgr !== 4'b0000) begin miscompares++; $display("FAIL rstpri_tg got=%b exp=0000", tgr); end
        rstr = 0; loadr = 0; tr = 4'b0001;
        tick();
        vectors++; if (qr !== 4'b1101) begin miscompares++; $display("FAIL rstpri_resume_q got=%b exp=1101", qr); end
        vectors++; if (tgr !== 4'b0001) begin miscompares++; $display("FAIL rstpri_resume_tg got=%b exp=0001", tgr); end
        vectors++; if (qnr !== 4'b0010) begin miscompares++; $display("FAIL rstpri_resume_qn got=%b exp=0010", qnr); end
    endtask

    task automatic test_back_to_back();
        // q1 is 0 here; continuous toggling gives a divide-by-2 square wave
        t1 = 1; en1 = 1; load1 = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++; if (q1 !== ((i % 2 == 0) ? 1'b1 : 1'b0)) begin miscompares++; $display("FAIL square_q[%0d] got=%b exp=%b", i, q1, (i % 2 == 0) ? 1'b1 : 1'b0); end
            vectors++; if (tg1 !== 1'b1) begin miscompares++; $display("FAIL square_tg[%0d] got=%b exp=1", i, tg1); end
        end
    endtask

    task automatic test_random();
        logic [3:0] mq, mt;
        rst4 = 1; load4 = 0; en4 = 0;
        tick();
        mq = 4'b0000;
        for (int i = 0; i < 1000; i++) begin
            rst4  = ($urandom_range(0, 15) == 0);
            load4 = ($urandom_range(0, 5) == 0);
            en4   = $urandom_range(0, 1) != 0;
            t4    = 4'($urandom_range(0, 15));
            d4    = 4'($urandom_range(0, 15));
            if (rst4) begin
                mt = 4'b0000; mq = 4'b0000;
            end else if (load4) begin
                mt = mq ^ d4; mq = d4;
            end else if (en4) begin
                mt = t4; mq = mq ^ t4;
            end else begin
                mt = 4'b0000;
            end
            tick();
            vectors++; if (q4 !== mq) begin miscompares++; $display("FAIL rand_q[%0d] got=%b exp=%b", i, q4, mq); end
            vectors++; if (tg4 !== mt) begin miscompares++; $display("FAIL rand_tg[%0d] got=%b exp=%b", i, tg4, mt); end
            vectors++; if (qn4 !== ~mq) begin miscompares++; $display("FAIL rand_qn[%0d] got=%b exp=%b", i, qn4, ~mq); end
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_toggle_pattern();
        test_enable_hold();
        test_load_priority();
        test_reset_priority();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
